// File: rtl/relu_seq_ctrl.sv
// relu_seq_ctrl: walks a feature-map buffer (columns, then rows, then plane
// groups), drives the buffer reads, delays the read strobe to line up with the
// relu array input, and turns the relu q_en output into write-back addresses.
module relu_seq_ctrl #(
  parameter int INPUT_NUM    = 6,
  parameter int WDP          = 9,
  parameter int IMG_W        = 24,
  parameter int IMG_H        = 24,
  parameter int NUM_GROUPS   = 1,
  parameter int ROW_STRIDE   = 24,
  parameter int GROUP_STRIDE = 576,
  parameter int RD_LAT       = 1,
  parameter int ADDR_W       = 10
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [ADDR_W-1:0] wr_base,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              relu_en,
  input  logic              relu_q_en,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              busy,
  output logic              done
);

  localparam int N  = IMG_W * IMG_H * NUM_GROUPS;
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int GW = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
  localparam int NW = (N > 1) ? $clog2(N) : 1;

  // Plane count and sample width only matter to the relu array; reject
  // configurations that cannot be sequenced at all.
  if (INPUT_NUM < 1 || WDP < 1 || RD_LAT < 1 || RD_LAT > 4 || ROW_STRIDE < IMG_W || N < 1) begin : g_cfg_err
    $error("relu_seq_ctrl: illegal parameter set");
  end

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     c_q, c_d;
  logic [RW-1:0]     r_q, r_d;
  logic [GW-1:0]     g_q, g_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] row_addr_q, row_addr_d;   // address of column 0 of the current row
  logic [ADDR_W-1:0] grp_addr_q, grp_addr_d;   // address of row 0 of the current group
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [NW-1:0]     wcnt_q, wcnt_d;
  logic [RD_LAT-1:0] vld_pipe_q, vld_pipe_d;

  logic c_last, r_last, g_last, last_rd, accept;

  assign c_last  = (c_q == CW'(IMG_W - 1));
  assign r_last  = (r_q == RW'(IMG_H - 1));
  assign g_last  = (g_q == GW'(NUM_GROUPS - 1));
  assign last_rd = c_last & r_last & g_last;
  assign accept  = (state_q == IDLE) & start;

  assign rd_en   = (state_q == RUN);
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign wr_en   = relu_q_en & busy;
  assign rd_addr = rd_addr_q;
  assign wr_addr = wr_addr_q;
  assign relu_en = vld_pipe_q[RD_LAT-1];

  if (RD_LAT == 1) begin : g_pipe1
    assign vld_pipe_d = rd_en;
  end else begin : g_pipeN
    assign vld_pipe_d = {vld_pipe_q[RD_LAT-2:0], rd_en};
  end

  // Next-state: frame phases; DRAIN waits for the final write-back.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_rd) state_d = DRAIN;
      DRAIN:   if (wr_en && wcnt_q == NW'(N - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read-address walk and write-back counter; strides are added incrementally
  // so no multiplier is needed, and everything wraps at 2^ADDR_W.
  always_comb begin
    c_d        = c_q;
    r_d        = r_q;
    g_d        = g_q;
    rd_addr_d  = rd_addr_q;
    row_addr_d = row_addr_q;
    grp_addr_d = grp_addr_q;
    wr_addr_d  = wr_addr_q;
    wcnt_d     = wcnt_q;
    if (accept) begin
      c_d        = '0;
      r_d        = '0;
      g_d        = '0;
      rd_addr_d  = rd_base;
      row_addr_d = rd_base;
      grp_addr_d = rd_base;
      wr_addr_d  = wr_base;
      wcnt_d     = '0;
    end else begin
      if (state_q == RUN) begin
        if (!c_last) begin
          c_d       = c_q + 1'b1;
          rd_addr_d = rd_addr_q + 1'b1;
        end else if (!r_last) begin
          c_d        = '0;
          r_d        = r_q + 1'b1;
          row_addr_d = row_addr_q + ADDR_W'(ROW_STRIDE);
          rd_addr_d  = row_addr_q + ADDR_W'(ROW_STRIDE);
        end else begin
          c_d        = '0;
          r_d        = '0;
          g_d        = g_last ? '0 : g_q + 1'b1;
          grp_addr_d = grp_addr_q + ADDR_W'(GROUP_STRIDE);
          row_addr_d = grp_addr_q + ADDR_W'(GROUP_STRIDE);
          rd_addr_d  = grp_addr_q + ADDR_W'(GROUP_STRIDE);
        end
      end
      if (wr_en) begin
        wcnt_d    = wcnt_q + 1'b1;
        wr_addr_d = wr_addr_q + 1'b1;
      end
    end
  end

  // State, counters, address registers and read-valid delay line.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      c_q        <= '0;
      r_q        <= '0;
      g_q        <= '0;
      rd_addr_q  <= '0;
      row_addr_q <= '0;
      grp_addr_q <= '0;
      wr_addr_q  <= '0;
      wcnt_q     <= '0;
      vld_pipe_q <= '0;
    end else begin
      state_q    <= state_d;
      c_q        <= c_d;
      r_q        <= r_d;
      g_q        <= g_d;
      rd_addr_q  <= rd_addr_d;
      row_addr_q <= row_addr_d;
      grp_addr_q <= grp_addr_d;
      wr_addr_q  <= wr_addr_d;
      wcnt_q     <= wcnt_d;
      vld_pipe_q <= vld_pipe_d;
    end
  end

endmodule

// File: doc/relu_seq_ctrl.md
# relu_seq_ctrl

Sequencer for the ReLU stage of the CNN accelerator. On a start pulse it walks a feature-map buffer of `NUM_GROUPS` groups of `INPUT_NUM` packed planes, row by row. It drives buffer reads, aligns `en` to the `relu` array's input and generates write-back addresses from the `relu` `q_en` output. It sits between the conv/pool buffer and the next layer's input buffer, and reports busy/done to the layer controller.

## Interface
- `INPUT_NUM`, 6, planes processed in parallel (matches `relu`)
- `WDP`, 9, bits per plane sample
- `IMG_W`, 24, columns per row
- `IMG_H`, 24, rows per plane
- `NUM_GROUPS`, 1, plane groups per frame
- `ROW_STRIDE`, 24, read-address step per row (≥ `IMG_W`; allows a padded source buffer)
- `GROUP_STRIDE`, 576, read-address step per group
- `RD_LAT`, 1, buffer read latency in cycles (1..4)
- `ADDR_W`, 10, address width

Ports:
- `clk`  in  1  clock, rising edge
- `rstn`  in  1  asynchronous active-low reset
- `start`  in  1  one-cycle request to process a frame
- `rd_base`  in  `ADDR_W`  source base address, latched when start is accepted
- `wr_base`  in  `ADDR_W`  destination base address, latched when start is accepted
- `rd_en`  out  1  buffer read strobe
- `rd_addr`  out  `ADDR_W`  buffer read address
- `relu_en`  out  1  to `relu` `en`, aligned with read data
- `relu_q_en`  in  1  from `relu` `q_en`
- `wr_en`  out  1  destination write strobe
- `wr_addr`  out  `ADDR_W`  destination write address
- `busy`  out  1  frame in progress
- `done`  out  1  one-cycle completion pulse

## Operation
- State machine: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - `start`=1 latches `rd_base` and `wr_base`, clears all counters and goes to RUN.
  - `start` is ignored in every other state; there is no queueing.
- RUN:
  - `rd_en`=1 every cycle.
  - `rd_addr = rd_base + g*GROUP_STRIDE + r*ROW_STRIDE + c`, computed mod 2^`ADDR_W`.
  - Counter order: `c` (0..`IMG_W`-1) innermost, then `r` (0..`IMG_H`-1), then `g` (0..`NUM_GROUPS`-1).
  - After the read with `c`=`IMG_W`-1, `r`=`IMG_H`-1 and `g`=`NUM_GROUPS`-1, go to DRAIN.
- Totals: N = `IMG_W`*`IMG_H`*`NUM_GROUPS` reads and N writes per frame.
- `relu_en` is `rd_en` delayed by exactly `RD_LAT` cycles through a shift register.
- Write side, independent of state:
  - `wr_en = relu_q_en & busy` (combinational).
  - `wr_addr = wr_base + wcnt`, mod 2^`ADDR_W`.
  - `wcnt` increments on each `wr_en`.
- DRAIN: `rd_en`=0. When the write with `wcnt`=N-1 occurs, go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- `busy` = state is RUN, DRAIN or DONE.
- Extra `relu_q_en` pulses in IDLE produce no write and do not change `wcnt`.
- Reset, including mid-frame:
  - Immediately: state IDLE; `rd_en`, `relu_en`, `wr_en`, `busy`, `done` = 0; `rd_addr`, `wr_addr` = 0.
  - All counters and the delay line are cleared.
  - No partial `done` is ever produced.

## Timing
- `start` sampled at edge k: RUN from cycle k+1.
- `rd_en` is high in cycles k+1 .. k+N.
- `relu_en` is high in cycles k+1+`RD_LAT` .. k+N+`RD_LAT`.
- With the `relu` block's 1-cycle register, `wr_en` is high in cycles k+2+`RD_LAT` .. k+N+1+`RD_LAT`.
- `done` is in cycle k+N+2+`RD_LAT`; `busy` is high from k+1 through that cycle.
- Earliest accepted restart: the cycle after `done`.
- A `start` held high continuously yields back-to-back frames separated by one IDLE cycle.
- Degenerate case N=1: one read, one write, `done` at k+3+`RD_LAT`.
- `rd_addr` and `wr_addr` are registered outputs. `rd_addr` is valid in the same cycle as `rd_en`.

## Test plan
- Basic frame:
  - Config: `IMG_W`=4, `IMG_H`=2, `NUM_GROUPS`=1, `ROW_STRIDE`=4, `RD_LAT`=1; `rd_base`=0x10, `wr_base`=0x80; `start` at cycle 0.
  - Required: `rd_addr` 0x10..0x17 in cycles 1–8; `relu_en` in cycles 2–9; `wr_addr` 0x80..0x87 in cycles 3–10; `done` in cycle 11; `busy` in cycles 1–11.
- Strides:
  - Config: `IMG_W`=3, `IMG_H`=2, `NUM_GROUPS`=2, `ROW_STRIDE`=5, `GROUP_STRIDE`=16, base 0.
  - Required read sequence: 0,1,2,5,6,7,16,17,18,21,22,23. Writes: 12 consecutive addresses.
- Latency: `RD_LAT`=3 on the basic frame → `relu_en` in cycles 4–11, `done` in cycle 13.
- Wrap: `ADDR_W`=4, `rd_base`=0xE on the basic frame → `rd_addr` sequence E,F,0,1,2,3,4,5.
- Start while busy: second `start` in cycle 5 of the basic frame → ignored; exactly 8 writes, one `done`.
- Reset mid-frame: `rstn` low in cycle 6 for 2 cycles → all outputs 0 immediately, no `done`. A new `start` afterwards runs a full, correct 8-write frame.
